// File: rtl/stop_light_pkg.sv
// Shared types and helpers for the multi-approach stop-light controller.
package stop_light_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    Y1     = 2'd1,
    ALLRED = 2'd2,
    Y2     = 2'd3
  } sl_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sl_phase_timer.sv
// Phase down-counter: load has priority, otherwise decrements to zero and holds.
module sl_phase_timer #(
  parameter int W = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         done
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/seq_fsm_stop_light_multi.sv
// Timed round-robin stop-light controller for NUM_DIRS approaches; at most one
// approach is non-red, phases are timed by sl_phase_timer, state is exposed on state_dbg.
module seq_fsm_stop_light_multi
  import stop_light_pkg::*;
#(
  parameter int NUM_DIRS      = 2,
  parameter int GREEN_CYCLES  = 8,
  parameter int MIN_GREEN     = 2,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1,
  localparam int DW = $clog2(NUM_DIRS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                starting_yellow,
  input  logic                change,
  output logic [NUM_DIRS-1:0] green_on,
  output logic [NUM_DIRS-1:0] yellow_on,
  output logic [NUM_DIRS-1:0] red_on,
  output logic [DW-1:0]       active_dir,
  output logic [1:0]          state_dbg
);

  localparam int TW = $clog2(max3(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES) + 1);

  localparam logic [TW-1:0] G_LOAD = TW'(GREEN_CYCLES - 1);
  localparam logic [TW-1:0] Y_LOAD = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] A_LOAD = TW'(ALLRED_CYCLES - 1);
  // Timer value at or below which at least MIN_GREEN green cycles have been shown.
  localparam logic [TW-1:0] CHG_LIMIT = TW'(GREEN_CYCLES - MIN_GREEN);
  localparam logic [DW-1:0] LAST_DIR  = DW'(NUM_DIRS - 1);

  sl_state_t           state, state_next;
  logic [DW-1:0]       dir_next;
  logic                t_load, t_dec, t_done;
  logic [TW-1:0]       t_load_val, t_cnt;
  logic                change_ok;
  logic [NUM_DIRS-1:0] dir_mask;

  sl_phase_timer #(
    .W       (TW),
    .RST_VAL (G_LOAD)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .cnt      (t_cnt),
    .done     (t_done)
  );

  assign change_ok = change && (t_cnt <= CHG_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= GREEN;
      active_dir <= '0;
    end else begin
      state      <= state_next;
      active_dir <= dir_next;
    end
  end

  always_comb begin
    state_next = state;
    dir_next   = active_dir;
    t_load     = 1'b0;
    t_load_val = '0;
    case (state)
      GREEN: begin
        if (t_done || change_ok) begin
          state_next = Y1;
          t_load     = 1'b1;
          t_load_val = Y_LOAD;
        end
      end
      Y1: begin
        if (t_done) begin
          state_next = ALLRED;
          t_load     = 1'b1;
          t_load_val = A_LOAD;
        end
      end
      ALLRED: begin
        if (t_done) begin
          dir_next = (active_dir == LAST_DIR) ? '0 : active_dir + DW'(1);
          t_load   = 1'b1;
          if (starting_yellow) begin
            state_next = Y2;
            t_load_val = Y_LOAD;
          end else begin
            state_next = GREEN;
            t_load_val = G_LOAD;
          end
        end
      end
      Y2: begin
        if (t_done) begin
          state_next = GREEN;
          t_load     = 1'b1;
          t_load_val = G_LOAD;
        end
      end
      default: begin
        state_next = ALLRED;
        t_load     = 1'b1;
        t_load_val = A_LOAD;
      end
    endcase
    t_dec = ~t_load;
  end

  assign dir_mask = NUM_DIRS'(1) << active_dir;

  always_comb begin
    green_on  = '0;
    yellow_on = '0;
    case (state)
      GREEN:   green_on  = dir_mask;
      Y1, Y2:  yellow_on = dir_mask;
      default: ;
    endcase
  end

  assign red_on    = ~(green_on | yellow_on);
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_fsm_stop_light_multi.sv
// Bench for seq_fsm_stop_light_multi: a 2-approach and a 3-approach instance share
// stimulus; a phase-level model is compared every cycle, plus directed traces.
module tb_seq_fsm_stop_light_multi;
  import stop_light_pkg::*;

  localparam int G   = 4;
  localparam int MIN = 2;
  localparam int Y   = 2;
  localparam int A   = 1;

  localparam int P_GO    = 1;
  localparam int P_CLEAR = 2;
  localparam int P_RED   = 3;
  localparam int P_PREP  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic starting_yellow = 1'b0;
  logic change = 1'b0;

  logic [1:0] g2, y2, r2, s2;
  logic [0:0] d2;
  logic [2:0] g3, y3, r3;
  logic [1:0] d3, s3;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  int m_ph[2];
  int m_dir[2];
  int m_shown[2];
  int nd[2] = '{2, 3};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seq_fsm_stop_light_multi #(
    .NUM_DIRS(2), .GREEN_CYCLES(G), .MIN_GREEN(MIN), .YELLOW_CYCLES(Y), .ALLRED_CYCLES(A)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .starting_yellow(starting_yellow), .change(change),
    .green_on(g2), .yellow_on(y2), .red_on(r2), .active_dir(d2), .state_dbg(s2)
  );

  seq_fsm_stop_light_multi #(
    .NUM_DIRS(3), .GREEN_CYCLES(G), .MIN_GREEN(MIN), .YELLOW_CYCLES(Y), .ALLRED_CYCLES(A)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .starting_yellow(starting_yellow), .change(change),
    .green_on(g3), .yellow_on(y3), .red_on(r3), .active_dir(d3), .state_dbg(s3)
  );

  // ---------------- model: phase kind + cycles shown so far ----------------
  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_ph[k]    <= P_GO;
        m_dir[k]   <= 0;
        m_shown[k] <= 0;
      end else begin
        m_shown[k] <= m_shown[k] + 1;
        case (m_ph[k])
          P_GO: if ((m_shown[k] + 1 == G) || (change && (m_shown[k] + 1 >= MIN))) begin
            m_ph[k] <= P_CLEAR; m_shown[k] <= 0;
          end
          P_CLEAR: if (m_shown[k] + 1 == Y) begin
            m_ph[k] <= P_RED; m_shown[k] <= 0;
          end
          P_RED: if (m_shown[k] + 1 == A) begin
            m_dir[k]   <= (m_dir[k] + 1) % nd[k];
            m_ph[k]    <= starting_yellow ? P_PREP : P_GO;
            m_shown[k] <= 0;
          end
          P_PREP: if (m_shown[k] + 1 == Y) begin
            m_ph[k] <= P_GO; m_shown[k] <= 0;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    logic [2:0] mask, eg, ey, er, full, ag, ay, ar;
    int ad;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        mask = 3'(1 << m_dir[k]);
        full = (k == 0) ? 3'b011 : 3'b111;
        eg = (m_ph[k] == P_GO) ? mask : 3'b000;
        ey = (m_ph[k] == P_CLEAR || m_ph[k] == P_PREP) ? mask : 3'b000;
        er = ~(eg | ey) & full;
        if (k == 0) begin
          ag = {1'b0, g2}; ay = {1'b0, y2}; ar = {1'b0, r2}; ad = int'(d2);
        end else begin
          ag = g3; ay = y3; ar = r3; ad = int'(d3);
        end
        chk($sformatf("model_green[%0d]", k), int'(ag), int'(eg));
        chk($sformatf("model_yellow[%0d]", k), int'(ay), int'(ey));
        chk($sformatf("model_red[%0d]", k), int'(ar), int'(er));
        chk($sformatf("model_dir[%0d]", k), ad, m_dir[k]);
        chk($sformatf("lamp_onehot[%0d]", k), int'($countones(ag | ay) <= 1), 1);
        chk($sformatf("red_complement[%0d]", k), int'(ar), int'(~(ag | ay) & full));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic sy, input logic ch);
    @(negedge clk);
    reset_n = 1'b0;
    starting_yellow = sy;
    change = ch;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_run(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Samples {green, yellow} of the 2-approach instance once per cycle.
  task automatic run_trace(input string name, input int n, input int sy_hi_at, input int sy_lo_at);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      #1;
      if (exp_q.size() == 0) begin
        chk({name, "_queue_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s[%0d]", name, i), int'({g2, y2}), int'(e));
      end
      if (i == sy_hi_at) starting_yellow = 1'b1;
      if (i == sy_lo_at) starting_yellow = 1'b0;
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int seen[$];
    int order[4];
    logic prev_g;
    order = '{0, 1, 2, 0};

    // Reset values
    do_reset(1'b0, 1'b0);
    #1;
    chk("rst_green2", int'(g2), 1);
    chk("rst_yellow2", int'(y2), 0);
    chk("rst_red2", int'(r2), 2);
    chk("rst_dir2", int'(d2), 0);
    chk("rst_red3", int'(r3), 6);
    chk("rst_state2", int'(s2), int'(GREEN));
    chk("rst_state3", int'(s3), int'(GREEN));

    // 1: plain timed cycle
    do_reset(1'b0, 1'b0);
    push_run(4'b0100, 4); push_run(4'b0001, 2); push_run(4'b0000, 1);
    push_run(4'b1000, 4); push_run(4'b0010, 2); push_run(4'b0000, 1);
    push_run(4'b0100, 1);
    run_trace("s1", 15, -1, -1);

    // 2: pre-green yellow enabled
    do_reset(1'b1, 1'b0);
    push_run(4'b0100, 4); push_run(4'b0001, 2); push_run(4'b0000, 1);
    push_run(4'b0010, 2); push_run(4'b1000, 4); push_run(4'b0010, 2);
    push_run(4'b0000, 1); push_run(4'b0001, 2); push_run(4'b0100, 1);
    run_trace("s2", 19, -1, -1);

    // 3: change held from reset
    do_reset(1'b0, 1'b1);
    push_run(4'b0100, 2); push_run(4'b0001, 2); push_run(4'b0000, 1);
    push_run(4'b1000, 2); push_run(4'b0010, 2); push_run(4'b0000, 1);
    push_run(4'b0100, 1);
    run_trace("s3", 11, -1, -1);

    // 4: three approaches served round-robin
    do_reset(1'b0, 1'b0);
    prev_g = 1'b0;
    for (int c = 0; c < 60 && seen.size() < 4; c++) begin
      #1;
      if (g3 != 3'b000 && !prev_g) seen.push_back(int'(d3));
      prev_g = (g3 != 3'b000);
      @(negedge clk);
    end
    chk("s4_green_entries", seen.size(), 4);
    for (int i = 0; i < seen.size() && i < 4; i++)
      chk($sformatf("s4_order[%0d]", i), seen[i], order[i]);

    // 5: async reset in the middle of Y2 on approach 1
    do_reset(1'b1, 1'b0);
    repeat (7) @(negedge clk);
    #1;
    chk("s5_in_y2", int'({g2, y2}), int'(4'b0010));
    #1;
    reset_n = 1'b0;
    #1;
    chk("s5_async_green", int'(g2), 1);
    chk("s5_async_yellow", int'(y2), 0);
    chk("s5_async_red", int'(r2), 2);
    chk("s5_async_dir", int'(d2), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push_run(4'b0100, 4); push_run(4'b0001, 1);
    run_trace("s5_post", 5, -1, -1);

    // 6: starting_yellow toggled mid-green and mid-Y2
    do_reset(1'b0, 1'b0);
    push_run(4'b0100, 4); push_run(4'b0001, 2); push_run(4'b0000, 1);
    push_run(4'b0010, 2); push_run(4'b1000, 4); push_run(4'b0010, 2);
    push_run(4'b0000, 1); push_run(4'b0100, 1);
    run_trace("s6", 17, 1, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
